// File: rtl/tmr_pkg.sv
// rtl/tmr_pkg.sv - Shared types, group count and majority helper for the TMR scrubber
package tmr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    CHECK  = 2'd2,
    REPAIR = 2'd3
  } scrub_state_t;

  localparam int NGROUPS = 4;
  localparam int VW      = 64;

  // Wide enough for any group slice; callers cast the result back to their slice width.
  function automatic logic [VW-1:0] vote3(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                          input logic [VW-1:0] c);
    return (a & b) | (b & c) | (a & c);
  endfunction

endpackage

// File: rtl/tmr_vote3.sv
// rtl/tmr_vote3.sv - Bitwise two-of-three majority across a full word
module tmr_vote3 #(
  parameter int W = 12
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] y
);

  assign y = (a & b) | (b & c) | (a & c);

endmodule

// File: rtl/tmr_scrubber.sv
// rtl/tmr_scrubber.sv - Majority-voted read port with background group scrub and repair strobes
module tmr_scrubber
  import tmr_pkg::*;
#(
  parameter int W            = 12,
  parameter int SCRUB_PERIOD = 1024,
  parameter int CW           = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [W-1:0]  copy_a,
  input  logic [W-1:0]  copy_b,
  input  logic [W-1:0]  copy_c,
  input  logic          wr_busy,
  input  logic          start,
  input  logic          clr_count,
  output logic [W-1:0]  q,
  output logic          fix_en,
  output logic [W-1:0]  fix_mask,
  output logic [W-1:0]  fix_data,
  output logic          err_valid,
  output logic [1:0]    err_group,
  output logic [2:0]    err_copy,
  output logic [CW-1:0] err_count,
  output logic          busy
);

  localparam int            G           = W / NGROUPS;
  localparam logic [31:0]   PERIOD_LAST = (SCRUB_PERIOD == 0) ? 32'd0 : 32'(SCRUB_PERIOD - 1);
  localparam logic [CW-1:0] CNT_MAX     = '1;

  scrub_state_t state, state_nx;
  logic [1:0]   grp, grp_nx;
  logic [31:0]  per_cnt;
  logic [G-1:0] sa, sb, sc;
  logic [G-1:0] v_chk, ma, mb, mc, mism;
  logic [G-1:0] fix_v, fix_m;
  logic [2:0]   fix_c;
  logic         trigger, repair_go, last_grp;

  tmr_vote3 #(.W(W)) u_vote (
    .a (copy_a),
    .b (copy_b),
    .c (copy_c),
    .y (q)
  );

  always_comb begin
    v_chk = G'(vote3(VW'(sa), VW'(sb), VW'(sc)));
    ma    = sa ^ v_chk;
    mb    = sb ^ v_chk;
    mc    = sc ^ v_chk;
    mism  = ma | mb | mc;
  end

  assign trigger   = (state == IDLE) &&
                     (start || ((SCRUB_PERIOD != 0) && (per_cnt == PERIOD_LAST)));
  // A repair collides with a functional write: drop it and resample, so data is never stale.
  assign repair_go = (state == REPAIR) && !wr_busy;
  assign last_grp  = (grp == 2'(NGROUPS - 1));
  assign busy      = (state != IDLE) || trigger;

  always_comb begin
    state_nx = state;
    grp_nx   = grp;
    case (state)
      IDLE: begin
        if (trigger) begin
          state_nx = SAMPLE;
          grp_nx   = 2'd0;
        end
      end
      SAMPLE: state_nx = CHECK;
      CHECK, REPAIR: begin
        if (wr_busy) begin
          state_nx = SAMPLE;
        end else if ((state == CHECK) && (mism != '0)) begin
          state_nx = REPAIR;
        end else if (last_grp) begin
          state_nx = IDLE;
        end else begin
          state_nx = SAMPLE;
          grp_nx   = grp + 2'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      grp     <= 2'd0;
      per_cnt <= '0;
      sa      <= '0;
      sb      <= '0;
      sc      <= '0;
      fix_v   <= '0;
      fix_m   <= '0;
      fix_c   <= '0;
    end else begin
      state   <= state_nx;
      grp     <= grp_nx;
      per_cnt <= (state == IDLE && !trigger) ? per_cnt + 32'd1 : '0;
      if (state == SAMPLE) begin
        sa <= copy_a[grp*G +: G];
        sb <= copy_b[grp*G +: G];
        sc <= copy_c[grp*G +: G];
      end
      if (state == CHECK) begin
        fix_v <= v_chk & mism;
        fix_m <= mism;
        fix_c <= {|mc, |mb, |ma};
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_count <= '0;
    end else if (clr_count) begin
      err_count <= repair_go ? CW'(1) : '0;
    end else if (repair_go && (err_count != CNT_MAX)) begin
      err_count <= err_count + 1'b1;
    end
  end

  always_comb begin
    fix_en    = repair_go;
    err_valid = repair_go;
    fix_mask  = '0;
    fix_data  = '0;
    err_group = 2'd0;
    err_copy  = 3'd0;
    if (repair_go) begin
      fix_mask[grp*G +: G] = fix_m;
      fix_data[grp*G +: G] = fix_v;
      err_group            = grp;
      err_copy             = fix_c;
    end
  end

endmodule

// File: tb/tb_tmr_scrubber.sv
// tb/tb_tmr_scrubber.sv - Directed self-checking bench for tmr_scrubber
module tb_tmr_scrubber;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [11:0] copy_a = 12'hA5A, copy_b = 12'hA5A, copy_c = 12'hA5A;
  logic        wr_busy = 1'b0, start = 1'b0, clr_count = 1'b0, start_p = 1'b0;

  logic [11:0] q0, fix_mask0, fix_data0;
  logic        fix_en0, err_valid0, busy0;
  logic [1:0]  err_group0;
  logic [2:0]  err_copy0;
  logic [7:0]  err_count0;

  logic [11:0] q_p, fix_mask_p, fix_data_p;
  logic        fix_en_p, err_valid_p, busy_p;
  logic [1:0]  err_group_p;
  logic [2:0]  err_copy_p;
  logic [7:0]  err_count_p;

  logic [11:0] q_s, fix_mask_s, fix_data_s;
  logic        fix_en_s, err_valid_s, busy_s;
  logic [1:0]  err_group_s;
  logic [2:0]  err_copy_s;
  logic [1:0]  err_count_s;

  int compared = 0, mismatched = 0;
  int stray;
  logic [11:0] ev_mask [4];
  logic [11:0] ev_data [4];
  logic [2:0]  ev_copy [4];
  logic [1:0]  ev_grp  [4];
  logic        ev_val  [4];
  int          ev_cyc  [4];

  always #5 clk = ~clk;

  tmr_scrubber #(.W(12), .SCRUB_PERIOD(0), .CW(8)) dut (
    .clk(clk), .rstn(rstn), .copy_a(copy_a), .copy_b(copy_b), .copy_c(copy_c),
    .wr_busy(wr_busy), .start(start), .clr_count(clr_count), .q(q0), .fix_en(fix_en0),
    .fix_mask(fix_mask0), .fix_data(fix_data0), .err_valid(err_valid0), .err_group(err_group0),
    .err_copy(err_copy0), .err_count(err_count0), .busy(busy0));

  tmr_scrubber #(.W(12), .SCRUB_PERIOD(16), .CW(8)) dut_p (
    .clk(clk), .rstn(rstn), .copy_a(copy_a), .copy_b(copy_b), .copy_c(copy_c),
    .wr_busy(wr_busy), .start(start_p), .clr_count(clr_count), .q(q_p), .fix_en(fix_en_p),
    .fix_mask(fix_mask_p), .fix_data(fix_data_p), .err_valid(err_valid_p), .err_group(err_group_p),
    .err_copy(err_copy_p), .err_count(err_count_p), .busy(busy_p));

  tmr_scrubber #(.W(12), .SCRUB_PERIOD(0), .CW(2)) dut_s (
    .clk(clk), .rstn(rstn), .copy_a(copy_a), .copy_b(copy_b), .copy_c(copy_c),
    .wr_busy(wr_busy), .start(start), .clr_count(clr_count), .q(q_s), .fix_en(fix_en_s),
    .fix_mask(fix_mask_s), .fix_data(fix_data_s), .err_valid(err_valid_s), .err_group(err_group_s),
    .err_copy(err_copy_s), .err_count(err_count_s), .busy(busy_s));

  // Cycle index i=0 is the trigger cycle; wr_busy and clr_count are raised at chosen indices.
  task automatic run_pass(input int wb_from, input int wb_len, input int clr_at,
                          output int cyc, output int nfix);
    bit done;
    done = 1'b0; cyc = 0; nfix = 0; stray = 0;
    @(negedge clk);
    for (int i = 0; i < 80 && !done; i++) begin
      start     = (i == 0);
      wr_busy   = (i >= wb_from) && (i < wb_from + wb_len);
      clr_count = (i == clr_at);
      #1;
      if (!busy0) begin
        done = 1'b1;
      end else begin
        cyc++;
        if (fix_en0) begin
          if (nfix < 4) begin
            ev_mask[nfix] = fix_mask0; ev_data[nfix] = fix_data0; ev_copy[nfix] = err_copy0;
            ev_grp[nfix] = err_group0; ev_val[nfix] = err_valid0; ev_cyc[nfix] = i;
          end
          nfix++;
        end else if (err_valid0 || fix_mask0 != 0 || fix_data0 != 0 || err_copy0 != 0 ||
                     err_group0 != 0) begin
          stray++;
        end
        @(negedge clk);
      end
    end
    start = 1'b0; wr_busy = 1'b0; clr_count = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr_count = 1'b1;
    @(negedge clk); clr_count = 1'b0;
  endtask

  task automatic test_reset();
    copy_a = 12'h0F0; copy_b = 12'h0FF; copy_c = 12'hF00;
    repeat (3) @(negedge clk);
    #1;
    compared++; if (q0 !== 12'h0F0) begin mismatched++; $display("FAIL reset_q: got %h want 0f0", q0); end
    compared++; if ({fix_en0, err_valid0, busy0} !== 3'b000) begin mismatched++; $display("FAIL reset_strobes: got %b want 000", {fix_en0, err_valid0, busy0}); end
    compared++; if ({fix_mask0, fix_data0} !== 24'h0) begin mismatched++; $display("FAIL reset_fix: got %h want 0", {fix_mask0, fix_data0}); end
    compared++; if ({err_group0, err_copy0, err_count0} !== 13'h0) begin mismatched++; $display("FAIL reset_err: got %h want 0", {err_group0, err_copy0, err_count0}); end
    copy_a = 12'hA5A; copy_b = 12'hA5A; copy_c = 12'hA5A;
    @(negedge clk); rstn = 1'b1;
  endtask

  task automatic test_clean_pass();
    int cyc, nfix;
    pulse_clr();
    run_pass(-1, 0, -1, cyc, nfix);
    compared++; if (cyc !== 9) begin mismatched++; $display("FAIL clean_busy_cycles: got %0d want 9", cyc); end
    compared++; if (nfix !== 0) begin mismatched++; $display("FAIL clean_fix_count: got %0d want 0", nfix); end
    compared++; if (err_count0 !== 8'd0) begin mismatched++; $display("FAIL clean_err_count: got %0d want 0", err_count0); end
    compared++; if (q0 !== 12'hA5A) begin mismatched++; $display("FAIL clean_q: got %h want a5a", q0); end
  endtask

  task automatic test_single_error();
    int cyc, nfix;
    pulse_clr();
    copy_b = 12'hA7A;
    run_pass(-1, 0, -1, cyc, nfix);
    compared++; if (q0 !== 12'hA5A) begin mismatched++; $display("FAIL single_q: got %h want a5a", q0); end
    compared++; if (cyc !== 10 || nfix !== 1) begin mismatched++; $display("FAIL single_counts: got cyc=%0d fix=%0d want 10/1", cyc, nfix); end
    compared++; if ({ev_mask[0], ev_data[0]} !== {12'h020, 12'h000}) begin mismatched++; $display("FAIL single_mask_data: got %h/%h want 020/000", ev_mask[0], ev_data[0]); end
    compared++; if ({ev_val[0], ev_copy[0], ev_grp[0]} !== {1'b1, 3'b010, 2'd1}) begin mismatched++; $display("FAIL single_report: got v=%b copy=%b grp=%0d want 1/010/1", ev_val[0], ev_copy[0], ev_grp[0]); end
    compared++; if (ev_cyc[0] !== 5 || stray !== 0) begin mismatched++; $display("FAIL single_timing: got at=%0d stray=%0d want 5/0", ev_cyc[0], stray); end
    compared++; if (err_count0 !== 8'd1) begin mismatched++; $display("FAIL single_err_count: got %0d want 1", err_count0); end
    copy_b = 12'hA5A;
  endtask

  task automatic test_two_copies();
    int cyc, nfix;
    pulse_clr();
    copy_a = 12'hA5B; copy_c = 12'h25A;
    run_pass(-1, 0, -1, cyc, nfix);
    compared++; if (q0 !== 12'hA5A) begin mismatched++; $display("FAIL two_q: got %h want a5a", q0); end
    compared++; if (cyc !== 11 || nfix !== 2) begin mismatched++; $display("FAIL two_counts: got cyc=%0d fix=%0d want 11/2", cyc, nfix); end
    compared++; if ({ev_grp[0], ev_copy[0], ev_mask[0], ev_data[0]} !== {2'd0, 3'b001, 12'h001, 12'h000}) begin mismatched++; $display("FAIL two_first: got grp=%0d copy=%b %h/%h want 0/001/001/000", ev_grp[0], ev_copy[0], ev_mask[0], ev_data[0]); end
    compared++; if ({ev_grp[1], ev_copy[1], ev_mask[1], ev_data[1]} !== {2'd3, 3'b100, 12'h800, 12'h800}) begin mismatched++; $display("FAIL two_second: got grp=%0d copy=%b %h/%h want 3/100/800/800", ev_grp[1], ev_copy[1], ev_mask[1], ev_data[1]); end
    compared++; if (err_count0 !== 8'd2) begin mismatched++; $display("FAIL two_err_count: got %0d want 2", err_count0); end
    copy_a = 12'hA5A; copy_c = 12'hA5A;
  endtask

  task automatic test_wr_busy_check();
    int cyc, nfix;
    pulse_clr();
    copy_a = 12'hA1A;
    run_pass(6, 3, -1, cyc, nfix);
    compared++; if (cyc !== 14 || nfix !== 1) begin mismatched++; $display("FAIL wrbusy_counts: got cyc=%0d fix=%0d want 14/1", cyc, nfix); end
    compared++; if (ev_cyc[0] !== 11) begin mismatched++; $display("FAIL wrbusy_fix_at: got %0d want 11", ev_cyc[0]); end
    compared++; if ({ev_grp[0], ev_copy[0], ev_mask[0], ev_data[0]} !== {2'd2, 3'b001, 12'h040, 12'h040}) begin mismatched++; $display("FAIL wrbusy_report: got grp=%0d copy=%b %h/%h want 2/001/040/040", ev_grp[0], ev_copy[0], ev_mask[0], ev_data[0]); end
    copy_a = 12'hA5A;
  endtask

  task automatic test_wr_busy_repair();
    int cyc, nfix;
    pulse_clr();
    copy_c = 12'hA58;
    run_pass(3, 1, -1, cyc, nfix);
    compared++; if (cyc !== 13 || nfix !== 1 || stray !== 0) begin mismatched++; $display("FAIL suppress_counts: got cyc=%0d fix=%0d stray=%0d want 13/1/0", cyc, nfix, stray); end
    compared++; if (ev_cyc[0] !== 6) begin mismatched++; $display("FAIL suppress_fix_at: got %0d want 6", ev_cyc[0]); end
    compared++; if ({ev_copy[0], ev_mask[0], ev_data[0]} !== {3'b100, 12'h002, 12'h002}) begin mismatched++; $display("FAIL suppress_report: got copy=%b %h/%h want 100/002/002", ev_copy[0], ev_mask[0], ev_data[0]); end
    compared++; if (err_count0 !== 8'd1) begin mismatched++; $display("FAIL suppress_err_count: got %0d want 1", err_count0); end
    copy_c = 12'hA5A;
  endtask

  task automatic test_periodic();
    bit prev, found;
    bit hist [61];
    int n1, n2;
    copy_a = 12'hA5A; copy_b = 12'hA5A; copy_c = 12'hA5A;
    prev = 1'b1; found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk); #1;
      if (!prev && busy_p) found = 1'b1;
      prev = busy_p;
    end
    compared++; if (!found) begin mismatched++; $display("FAIL periodic_sync: got no auto pass want one within 100 cycles"); end
    hist[0] = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      start_p = (i == 3) || (i == 24) || (i == 30);
      #1;
      hist[i] = busy_p;
    end
    start_p = 1'b0;
    n1 = 0; n2 = 0;
    for (int i = 0; i < 24; i++) begin n1 += int'(hist[i]); n2 += int'(hist[i + 24]); end
    compared++; if (n1 !== 9) begin mismatched++; $display("FAIL periodic_len1: got %0d want 9", n1); end
    compared++; if ({hist[23], hist[24]} !== 2'b01) begin mismatched++; $display("FAIL periodic_rise2: got %b want 01", {hist[23], hist[24]}); end
    compared++; if (n2 !== 9) begin mismatched++; $display("FAIL periodic_len2: got %0d want 9", n2); end
    compared++; if ({hist[47], hist[48]} !== 2'b01) begin mismatched++; $display("FAIL periodic_rise3: got %b want 01", {hist[47], hist[48]}); end
  endtask

  task automatic test_saturate();
    int cyc, nfix;
    pulse_clr();
    copy_a = 12'h813;
    run_pass(-1, 0, -1, cyc, nfix);
    compared++; if (cyc !== 13 || nfix !== 4) begin mismatched++; $display("FAIL sat_pass1: got cyc=%0d fix=%0d want 13/4", cyc, nfix); end
    compared++; if (err_count_s !== 2'd3 || err_count0 !== 8'd4) begin mismatched++; $display("FAIL sat_count1: got %0d/%0d want 3/4", err_count_s, err_count0); end
    copy_a = 12'hA5B;
    run_pass(-1, 0, -1, cyc, nfix);
    compared++; if (err_count_s !== 2'd3 || err_count0 !== 8'd5) begin mismatched++; $display("FAIL sat_count2: got %0d/%0d want 3/5", err_count_s, err_count0); end
    run_pass(-1, 0, 3, cyc, nfix);
    compared++; if (nfix !== 1 || ev_cyc[0] !== 3) begin mismatched++; $display("FAIL clr_repair_event: got fix=%0d at=%0d want 1/3", nfix, ev_cyc[0]); end
    compared++; if (err_count_s !== 2'd1 || err_count0 !== 8'd1) begin mismatched++; $display("FAIL clr_with_repair: got %0d/%0d want 1/1", err_count_s, err_count0); end
  endtask

  task automatic test_reset_mid_repair();
    copy_a = 12'hA5B;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    compared++; if ({fix_en0, fix_mask0} !== {1'b1, 12'h001}) begin mismatched++; $display("FAIL midrst_pre: got en=%b mask=%h want 1/001", fix_en0, fix_mask0); end
    rstn = 1'b0; #1;
    compared++; if ({fix_en0, err_valid0, busy0} !== 3'b000) begin mismatched++; $display("FAIL midrst_strobes: got %b want 000", {fix_en0, err_valid0, busy0}); end
    compared++; if ({fix_mask0, fix_data0, err_group0, err_copy0, err_count0} !== 37'h0) begin mismatched++; $display("FAIL midrst_fields: got %h want 0", {fix_mask0, fix_data0, err_group0, err_copy0, err_count0}); end
    @(negedge clk); rstn = 1'b1; copy_a = 12'hA5A;
  endtask

  initial begin
    test_reset();
    test_clean_pass();
    test_single_error();
    test_two_copies();
    test_wr_busy_check();
    test_wr_busy_repair();
    test_periodic();
    test_saturate();
    test_reset_mid_repair();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
